// File: rtl/uart_boot_loader_if.sv
// BSRAM write-port bundle driven by the UART boot loader.
//
// Write handshake: mem_wre is a one-cycle strobe with no back-pressure.
// mem_ad and mem_din are valid in exactly the cycle mem_wre is high, and
// mem_ce always mirrors mem_wre. There is no ready; the memory must accept
// every strobe.
interface uart_boot_loader_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16
) ();
    logic              mem_ce;
    logic              mem_wre;
    logic [ADDR_W-1:0] mem_ad;
    logic [DATA_W-1:0] mem_din;

    modport master (
        output mem_ce,
        output mem_wre,
        output mem_ad,
        output mem_din
    );

    modport slave (
        input mem_ce,
        input mem_wre,
        input mem_ad,
        input mem_din
    );
endinterface

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: serial program loader.
// Receives a framed image on uart_rx (8N1, LSB first):
//   0xA5 | LEN_HI | LEN_LO | {W_HI W_LO} x LEN | [CSUM]
// and writes each 16-bit word into the program BSRAM from address 0 upward.
// boot_mode keeps the CPU off the memory port until the image is accepted.
// Optional feature macro: BOOT_CSUM_EN adds a trailing modulo-256 checksum
// byte (sum of LEN_HI, LEN_LO and all data bytes); without it the load
// finishes straight after the last word is written.
// Both FSM states are exported on rx_state_dbg / ld_state_dbg.
module uart_boot_loader #(
    parameter int CLK_HZ = 27_000_000,
    parameter int BAUD   = 115_200,
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               uart_rx,
    uart_boot_loader_if.master mem,
    output logic               boot_mode,
    output logic               boot_done,
    output logic               boot_err,
    output logic [1:0]         rx_state_dbg,
    output logic [2:0]         ld_state_dbg
);

    // ------------------------------------------------------------------
    // Bit timing
    // ------------------------------------------------------------------
    localparam int          CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int          HALF_BIT     = CLKS_PER_BIT / 2;
    localparam logic [15:0] CNT_BIT_END  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] CNT_HALF_END = 16'(HALF_BIT - 1);

    // Receiver states
    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    // Loader states
    localparam logic [2:0] LD_SYNC    = 3'd0;
    localparam logic [2:0] LD_LEN_HI  = 3'd1;
    localparam logic [2:0] LD_LEN_LO  = 3'd2;
    localparam logic [2:0] LD_DATA_HI = 3'd3;
    localparam logic [2:0] LD_DATA_LO = 3'd4;
`ifdef BOOT_CSUM_EN
    localparam logic [2:0] LD_CSUM    = 3'd5;
`endif
    localparam logic [2:0] LD_DONE    = 3'd6;
    localparam logic [2:0] LD_ERR     = 3'd7;

    // Where the loader goes once the data section is complete (or empty)
`ifdef BOOT_CSUM_EN
    localparam logic [2:0] LD_AFTER_DATA = LD_CSUM;
`else
    localparam logic [2:0] LD_AFTER_DATA = LD_DONE;
`endif

    localparam logic [7:0]  SYNC_BYTE = 8'hA5;
    // Largest legal word count: exactly fills the memory
    localparam logic [16:0] LEN_MAX   = 17'd1 << ADDR_W;

    // ------------------------------------------------------------------
    // Receiver signals
    // ------------------------------------------------------------------
    logic        rx_s1;
    logic        rx_s2;
    logic        rx_prev;
    logic [1:0]  rx_state;
    logic [15:0] cnt_q;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        byte_valid;
    logic        frame_err;
    logic [7:0]  rx_byte;

    // ------------------------------------------------------------------
    // Loader signals
    // ------------------------------------------------------------------
    logic [2:0]        ld_state;
    logic [15:0]       len_q;
    logic [15:0]       len_next;
    logic [7:0]        hi_q;
    logic [ADDR_W:0]   word_idx;
    logic              wre_q;
    logic [ADDR_W-1:0] ad_q;
    logic [DATA_W-1:0] din_q;

    // The shift register holds the last byte until the next frame's data
    // bits arrive, far later than the loader consumes it.
    assign rx_byte  = shreg;
    assign len_next = {len_q[15:8], rx_byte};

    // 2-FF synchroniser plus one delayed copy for falling-edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= uart_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // Byte receiver: mid-start re-check rejects glitches, then 8 data bits
    // and a stop bit sampled one bit period apart
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state   <= RX_IDLE;
            cnt_q      <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_s2) begin
                        rx_state <= RX_START;
                        cnt_q    <= '0;
                    end
                end
                RX_START: begin
                    if (cnt_q == CNT_HALF_END) begin
                        cnt_q    <= '0;
                        bit_idx  <= '0;
                        // Line back high at mid-start: treat as noise
                        rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (cnt_q == CNT_BIT_END) begin
                        cnt_q   <= '0;
                        shreg   <= {rx_s2, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            rx_state <= RX_STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (cnt_q == CNT_BIT_END) begin
                        cnt_q    <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_s2) begin
                            byte_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

`ifdef BOOT_CSUM_EN
    logic [7:0] csum_q;

    // Running modulo-256 sum of the length and data bytes of the current frame
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else if (byte_valid) begin
            if (ld_state == LD_SYNC || ld_state == LD_ERR) begin
                if (rx_byte == SYNC_BYTE) begin
                    csum_q <= '0;
                end
            end else if (ld_state == LD_LEN_HI || ld_state == LD_LEN_LO ||
                         ld_state == LD_DATA_HI || ld_state == LD_DATA_LO) begin
                csum_q <= csum_q + rx_byte;
            end
        end
    end
`endif

    // Frame parser and BSRAM writer; DONE is terminal until reset, ERR hunts
    // for a new sync byte exactly like SYNC
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ld_state  <= LD_SYNC;
            len_q     <= '0;
            hi_q      <= '0;
            word_idx  <= '0;
            wre_q     <= 1'b0;
            ad_q      <= '0;
            din_q     <= '0;
            boot_mode <= 1'b1;
            boot_done <= 1'b0;
            boot_err  <= 1'b0;
        end else begin
            wre_q <= 1'b0;
            case (ld_state)
                LD_SYNC, LD_ERR: begin
                    // Frame errors and non-sync bytes are ignored while hunting
                    if (byte_valid && rx_byte == SYNC_BYTE) begin
                        ld_state <= LD_LEN_HI;
                        word_idx <= '0;
                        boot_err <= 1'b0;
                    end
                end
                LD_LEN_HI: begin
                    if (frame_err) begin
                        ld_state <= LD_ERR;
                        boot_err <= 1'b1;
                    end else if (byte_valid) begin
                        len_q[15:8] <= rx_byte;
                        ld_state    <= LD_LEN_LO;
                    end
                end
                LD_LEN_LO: begin
                    if (frame_err) begin
                        ld_state <= LD_ERR;
                        boot_err <= 1'b1;
                    end else if (byte_valid) begin
                        len_q[7:0] <= rx_byte;
                        if (len_next == 16'd0) begin
                            ld_state <= LD_AFTER_DATA;
                        end else if (17'(len_next) > LEN_MAX) begin
                            ld_state <= LD_ERR;
                            boot_err <= 1'b1;
                        end else begin
                            ld_state <= LD_DATA_HI;
                        end
                    end
                end
                LD_DATA_HI: begin
                    if (frame_err) begin
                        ld_state <= LD_ERR;
                        boot_err <= 1'b1;
                    end else if (byte_valid) begin
                        hi_q     <= rx_byte;
                        ld_state <= LD_DATA_LO;
                    end
                end
                LD_DATA_LO: begin
                    if (frame_err) begin
                        ld_state <= LD_ERR;
                        boot_err <= 1'b1;
                    end else if (byte_valid) begin
                        wre_q    <= 1'b1;
                        ad_q     <= word_idx[ADDR_W-1:0];
                        din_q    <= DATA_W'({hi_q, rx_byte});
                        word_idx <= word_idx + 1'b1;
                        // The index is one bit wider than the address so a
                        // full-memory image ends without wrapping
                        if (17'(word_idx) + 17'd1 == 17'(len_q)) begin
                            ld_state <= LD_AFTER_DATA;
                        end else begin
                            ld_state <= LD_DATA_HI;
                        end
                    end
                end
`ifdef BOOT_CSUM_EN
                LD_CSUM: begin
                    if (frame_err) begin
                        ld_state <= LD_ERR;
                        boot_err <= 1'b1;
                    end else if (byte_valid) begin
                        if (rx_byte == csum_q) begin
                            ld_state <= LD_DONE;
                        end else begin
                            ld_state <= LD_ERR;
                            boot_err <= 1'b1;
                        end
                    end
                end
`endif
                LD_DONE: begin
                    // Hand the memory port to the CPU; words already written stay
                    boot_done <= 1'b1;
                    boot_mode <= 1'b0;
                end
                default: ld_state <= LD_SYNC;
            endcase
        end
    end

    assign mem.mem_wre = wre_q;
    assign mem.mem_ce  = wre_q;
    assign mem.mem_ad  = ad_q;
    assign mem.mem_din = din_q;

    assign rx_state_dbg = rx_state;
    assign ld_state_dbg = ld_state;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Testbench for uart_boot_loader. Uses a fast bit clock (16 clocks per bit)
// and a 16-word memory so full-image and over-length cases stay short.
// A stream-level reference model parses whole byte streams and predicts the
// writes (scoreboard queue) and the final done/err state.
`timescale 1ns/1ps
module tb_uart_boot_loader;
    localparam int CLK_HZ = 16;
    localparam int BAUD   = 1;
    localparam int CPB    = CLK_HZ / BAUD;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 16;
    localparam int W      = ADDR_W + DATA_W;
`ifdef BOOT_CSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    typedef logic [7:0]  byte_q_t[$];
    typedef logic [15:0] word_q_t[$];

    logic       clk = 1'b0;
    logic       rst_n;
    logic       uart_rx;
    logic       boot_mode;
    logic       boot_done;
    logic       boot_err;
    logic [1:0] rx_state_dbg;
    logic [2:0] ld_state_dbg;

    uart_boot_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_if ();

    uart_boot_loader #(
        .CLK_HZ(CLK_HZ),
        .BAUD  (BAUD),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .uart_rx     (uart_rx),
        .mem         (mem_if.master),
        .boot_mode   (boot_mode),
        .boot_done   (boot_done),
        .boot_err    (boot_err),
        .rx_state_dbg(rx_state_dbg),
        .ld_state_dbg(ld_state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #950_000;
        $display("FAIL watchdog: observed no finish, required finish before 95000 cycles");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0]      exp_q[$];
    int                n_checks = 0;
    int                n_errors = 0;
    logic              m_done = 1'b0;
    logic              m_err  = 1'b0;
    logic [ADDR_W-1:0] last_ad = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Every write strobe is matched against the next expected {addr, data}
    always @(negedge clk) begin : write_monitor
        logic [W-1:0] exp_w;
        if (mem_if.mem_wre || mem_if.mem_ce) begin
            check("ce_eq_wre", 32'(mem_if.mem_ce), 32'(mem_if.mem_wre));
            if (mem_if.mem_wre) begin
                last_ad = mem_if.mem_ad;
                check("write_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    exp_w = exp_q.pop_front();
                    check("write_addr_data", 32'({mem_if.mem_ad, mem_if.mem_din}), 32'(exp_w));
                end
            end
        end
    end

    // ---------------- reference model ----------------
    // Parses a complete byte stream from the hunting state. bad is the index
    // of the byte sent with a broken stop bit (-1 for none).
    task automatic model_stream(input byte_q_t b, input int bad);
        int i, s, len, last, lo;
        logic [7:0] sum;
        i = 0;
        while (i < b.size() && !m_done) begin
            if (i == bad || b[i] != 8'hA5) begin
                i++;
            end else begin
                s = i;
                m_err = 1'b0;
                if (bad > s && bad <= s + 2) begin
                    m_err = 1'b1;
                    i = bad + 1;
                end else begin
                    len = int'({b[s+1], b[s+2]});
                    if (len > (1 << ADDR_W)) begin
                        m_err = 1'b1;
                        i = s + 3;
                    end else begin
                        last = s + 2 + 2 * len + (CSUM_EN ? 1 : 0);
                        sum  = 8'(b[s+1] + b[s+2]);
                        for (int k = 0; k < len; k++) begin
                            lo = s + 4 + 2 * k;
                            if (bad > s && bad <= lo) break;
                            exp_q.push_back({ADDR_W'(k), b[lo-1], b[lo]});
                            sum = 8'(sum + b[lo-1] + b[lo]);
                        end
                        if (bad > s && bad <= last) begin
                            m_err = 1'b1;
                            i = bad + 1;
                        end else begin
                            if (!CSUM_EN || b[last] == sum) m_done = 1'b1;
                            else m_err = 1'b1;
                            i = last + 1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic build_frame(input word_q_t words, output byte_q_t f);
        logic [7:0] sum;
        f = {};
        f.push_back(8'hA5);
        f.push_back(8'(words.size() >> 8));
        f.push_back(8'(words.size()));
        foreach (words[k]) begin
            f.push_back(words[k][15:8]);
            f.push_back(words[k][7:0]);
        end
        if (CSUM_EN) begin
            sum = 8'h00;
            for (int k = 1; k < f.size(); k++) sum = 8'(sum + f[k]);
            f.push_back(sum);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            uart_rx = b[k];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_range(input byte_q_t b, input int from, input int to, input int bad);
        for (int k = from; k <= to; k++) send_byte(b[k], k != bad);
    endtask

    task automatic send_all(input byte_q_t b, input int bad);
        send_range(b, 0, b.size() - 1, bad);
    endtask

    task automatic glitch();
        uart_rx = 1'b0;
        repeat (2) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic settle();
        repeat (3 * CPB) @(negedge clk);
    endtask

    task automatic do_reset();
        uart_rx = 1'b1;
        rst_n   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        m_done  = 1'b0;
        m_err   = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_mode"}, 32'(boot_mode), 32'd1);
        check({tag, "_done"}, 32'(boot_done), 32'd0);
        check({tag, "_err"},  32'(boot_err),  32'd0);
        check({tag, "_wre"},  32'(mem_if.mem_wre), 32'd0);
        check({tag, "_ce"},   32'(mem_if.mem_ce),  32'd0);
        check({tag, "_ad"},   32'(mem_if.mem_ad),  32'd0);
        check({tag, "_din"},  32'(mem_if.mem_din), 32'd0);
    endtask

    task automatic check_status(input string tag);
        check({tag, "_done"},    32'(boot_done), 32'(m_done));
        check({tag, "_err"},     32'(boot_err),  32'(m_err));
        check({tag, "_mode"},    32'(boot_mode), 32'(!m_done));
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        word_q_t w;
        byte_q_t f;
        byte_q_t s;
        logic [7:0] g;
        int n;

        // Reset values
        uart_rx = 1'b1;
        rst_n   = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Two-word load
        w = {}; w.push_back(16'h1234); w.push_back(16'hABCD);
        build_frame(w, f);
        model_stream(f, -1);
        send_all(f, -1);
        settle();
        check_status("t1");

        // Garbage before sync, glitch while waiting for LEN_HI
        do_reset();
        w = {}; w.push_back(16'h00A1);
        build_frame(w, f);
        s = {}; s.push_back(8'hFF); s.push_back(8'h00);
        foreach (f[k]) s.push_back(f[k]);
        model_stream(s, -1);
        send_range(s, 0, 2, -1);
        glitch();
        send_range(s, 3, s.size() - 1, -1);
        settle();
        check_status("t2");

        // Broken stop bit on the second data byte, then a clean resend
        do_reset();
        w = {}; w.push_back(16'h1234); w.push_back(16'hABCD);
        build_frame(w, f);
        model_stream(f, 4);
        send_all(f, 4);
        settle();
        check_status("t3_err");
        model_stream(f, -1);
        send_range(f, 0, 0, -1);
        check("t3_err_cleared", 32'(boot_err), 32'd0);
        send_range(f, 1, f.size() - 1, -1);
        settle();
        check_status("t3_resend");

        // Over-length image, then a memory-filling image, then ignored bytes
        do_reset();
        s = {}; s.push_back(8'hA5); s.push_back(8'h00); s.push_back(8'(17));
        model_stream(s, -1);
        send_all(s, -1);
        settle();
        check_status("t4_len_err");
        w = {};
        for (int k = 0; k < (1 << ADDR_W); k++) w.push_back(16'($urandom_range(0, 16'hFFFF)));
        build_frame(w, f);
        model_stream(f, -1);
        send_all(f, -1);
        settle();
        check_status("t4_full");
        check("t4_last_ad", 32'(last_ad), 32'((1 << ADDR_W) - 1));
        w = {}; w.push_back(16'h1122);
        build_frame(w, f);
        model_stream(f, -1);
        send_all(f, -1);
        settle();
        check_status("t4_after_done");

`ifdef BOOT_CSUM_EN
        // Wrong checksum: words land but the image is rejected
        do_reset();
        w = {}; w.push_back(16'h1234); w.push_back(16'hABCD);
        build_frame(w, f);
        f[f.size() - 1] = 8'h00;
        model_stream(f, -1);
        send_all(f, -1);
        settle();
        check_status("t5_csum");
`endif

        // Reset pulse in the middle of the DATA_LO byte
        do_reset();
        w = {}; w.push_back(16'h1234); w.push_back(16'hABCD);
        build_frame(w, f);
        model_stream(f, 6);
        send_range(f, 0, 5, -1);
        check("t6_pre_reset_pending", 32'(exp_q.size()), 32'd0);
        fork
            send_byte(f[6], 1'b1);
            begin
                repeat (4 * CPB + CPB / 2) @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                check_reset_values("t6");
                rst_n = 1'b1;
            end
        join
        m_done = 1'b0;
        m_err  = 1'b0;
        repeat (8 * CPB) @(negedge clk);
        check_status("t6_after_reset");
        model_stream(f, -1);
        send_all(f, -1);
        settle();
        check_status("t6_reload");

        // Random garbage prefixes and random images
        for (int it = 0; it < 3; it++) begin
            do_reset();
            s = {};
            n = int'($urandom_range(0, 3));
            for (int k = 0; k < n; k++) begin
                g = 8'($urandom_range(0, 255));
                if (g == 8'hA5) g = 8'h5A;
                s.push_back(g);
            end
            w = {};
            n = int'($urandom_range(1, 5));
            for (int k = 0; k < n; k++) w.push_back(16'($urandom_range(0, 16'hFFFF)));
            build_frame(w, f);
            foreach (f[k]) s.push_back(f[k]);
            model_stream(s, -1);
            send_all(s, -1);
            settle();
            check_status("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
